mem_request_unit: RTL and testbench
===================================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 Parameter MEM_WORDS, default 1024, SHALL set the number of 64-bit words addressable in data memory.
REQ-002 Parameter DATA_W, default 64, SHALL set the width of data and address buses.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Stage-side ports SHALL be:
- start, in, 1: stage operands valid.
- icode, in, 4: instruction code.
- valA, valE, valP, in, 64 each: stage operands.
- busy, out, 1: request in progress.
- done, out, 1: one-cycle completion pulse.
- valM, out, 64: read result.
- mem_err, out, 1: address error status.
REQ-006 Memory-side ports SHALL be:
- req_valid, out, 1; req_write, out, 1; req_addr, out, 64; req_wdata, out, 64.
- req_ready, in, 1.
- rsp_valid, in, 1; rsp_rdata, in, 64.

Function
REQ-007 Decode SHALL mark icode 4 (rmmovq), 8 (call) and A (pushq) as writes, and 5 (mrmovq), 9 (ret) and B (popq) as reads; all other icodes make no access.
REQ-008 Address SHALL be valA for icode 9 and valE for every other access; write data SHALL be valP for icode 8 and valA for icodes 4 and A.
REQ-009 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-010 IDLE SHALL move to REQ when start=1 and the icode accesses memory, and to DONE when start=1 and the icode makes no access.
REQ-011 REQ SHALL assert req_valid with req_write, req_addr and req_wdata held stable until req_ready=1.
REQ-012 On req_ready=1 in REQ, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-013 WAIT SHALL hold until rsp_valid=1, then capture rsp_rdata into valM and go to DONE.
REQ-014 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in REQ, WAIT and DONE, and 0 in IDLE.
REQ-016 start while busy=1 SHALL be ignored; operands SHALL be latched only on the IDLE accept cycle.
REQ-017 rsp_valid outside WAIT SHALL be ignored, and valM SHALL change only on a read capture.
REQ-018 Minimum latency from the start cycle T SHALL be:
- no-access: done at T+1.
- write with immediate ready: done at T+2.
- read with immediate ready and response: done at T+3.
REQ-019 req_ready and rsp_valid asserted together in REQ SHALL be treated as ready only; the response SHALL be taken in WAIT.

Reset
REQ-020 With rst_n=0 at a clock edge, the state SHALL go to IDLE, and req_valid, req_write, busy, done and mem_err SHALL go to 0.
REQ-021 With rst_n=0 at a clock edge, valM, req_addr and req_wdata SHALL go to 64'd0.
REQ-022 Reset mid-operation SHALL abandon the transaction, drop req_valid at that edge, and produce no done pulse.

Configuration
REQ-023 With macro MEM_BOUNDS_CHECK_EN defined, an access whose address is >= MEM_WORDS SHALL skip REQ: IDLE goes to DONE with mem_err=1 for the done cycle and no req_valid is issued.
REQ-024 With MEM_BOUNDS_CHECK_EN undefined, mem_err SHALL be constant 0 and all addresses SHALL be forwarded unchanged.

Structure
REQ-025 Package y86_mem_pkg SHALL hold:
- icode constants (IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ);
- the FSM state enum;
- the MEM_WORDS default.
REQ-026 Sub-module mem_op_decode SHALL be combinational, mapping icode to is_read, is_write, addr_sel and wdata_sel; the FSM and registers stay in mem_request_unit.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- rmmovq (icode 4), valA=0x55, valE=0x10, req_ready tied 1 -> req_write=1, addr 0x10, wdata 0x55; done at T+2; valM unchanged.
- mrmovq (icode 5), valE=0x20, req_ready delayed 3 cycles, rsp_rdata=0xABCD after 2 more -> valM=0xABCD; req fields stable throughout the stall.
- call (icode 8), valE=0x3F8, valP=0x1234 -> write of 0x1234 to 0x3F8; then ret (icode 9), valA=0x3F8 with response 0x1234 -> read address 0x3F8, valM=0x1234.
- nop (icode 1) -> no req_valid; done at T+1; start pulsed during busy is ignored.
- rst_n=0 during WAIT -> IDLE next edge, req_valid=0, no done pulse.
- With MEM_BOUNDS_CHECK_EN, popq (icode B), valE=1024 -> mem_err=1 with done at T+1, no request; without the macro, a request is issued to address 1024.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// Shared Y86 memory-stage definitions: icodes, FSM states, mux selects.
// Imported by mem_op_decode and mem_request_unit.
package y86_mem_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        ADDR_VALE,
        ADDR_VALA
    } addr_sel_t;

    typedef enum logic {
        WDATA_VALA,
        WDATA_VALP
    } wdata_sel_t;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational icode decode for the memory stage:
// access direction plus address and write-data source selects.
module mem_op_decode
    import y86_mem_pkg::*;
(
    input  logic [3:0] icode,
    output logic       is_read,
    output logic       is_write,
    output addr_sel_t  addr_sel,
    output wdata_sel_t wdata_sel
);

    always_comb begin
        is_read   = 1'b0;
        is_write  = 1'b0;
        addr_sel  = ADDR_VALE;
        wdata_sel = WDATA_VALA;
        unique case (icode)
            IRMMOVQ, IPUSHQ: is_write = 1'b1;
            ICALL: begin
                is_write  = 1'b1;
                wdata_sel = WDATA_VALP;
            end
            IMRMOVQ, IPOPQ: is_read = 1'b1;
            IRET: begin
                is_read  = 1'b1;
                addr_sel = ADDR_VALA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_request_unit.sv
// Y86 memory-stage request FSM: IDLE -> REQ -> WAIT -> DONE with registered outputs.
// Optional macro MEM_BOUNDS_CHECK_EN: out-of-range addresses finish with mem_err.
module mem_request_unit
    import y86_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] valM,
    output logic              mem_err,
    output logic              req_valid,
    output logic              req_write,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);

    state_t            state;
    logic              is_read;
    logic              is_write;
    addr_sel_t         addr_sel;
    wdata_sel_t        wdata_sel;
    logic              access;
    logic              addr_bad;
    logic [DATA_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;

    mem_op_decode u_decode (
        .icode     (icode),
        .is_read   (is_read),
        .is_write  (is_write),
        .addr_sel  (addr_sel),
        .wdata_sel (wdata_sel)
    );

    assign access     = is_read | is_write;
    assign addr_next  = (addr_sel == ADDR_VALA) ? valA : valE;
    assign wdata_next = (wdata_sel == WDATA_VALP) ? valP : valA;

`ifdef MEM_BOUNDS_CHECK_EN
    assign addr_bad = (addr_next >= DATA_W'(MEM_WORDS));
`else
    logic unused_limit;
    assign addr_bad     = 1'b0;
    assign unused_limit = (addr_next >= DATA_W'(MEM_WORDS));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_err   <= 1'b0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            valM      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!access || addr_bad) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            mem_err <= access & addr_bad;
                        end else begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_write <= is_write;
                            req_addr  <= addr_next;
                            req_wdata <= wdata_next;
                        end
                    end
                end
                // a response arriving alongside ready is ignored here
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (req_write) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        valM  <= rsp_rdata;
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    mem_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: directed table, reset-in-WAIT sequence,
// and randomized ops against a memory-level reference model.
module tb_mem_request_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valA = '0;
    logic [63:0] valE = '0;
    logic [63:0] valP = '0;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic        mem_err;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [63:0] rsp_rdata = '0;

    int total = 0;
    int bad   = 0;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] a;
        logic [63:0] e;
        logic [63:0] p;
        int          rdly;
        int          sdly;
        logic [63:0] rdata;
        bit          poke;
        bit          junk;
        bit          exp_req;
        bit          exp_w;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_valm;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    vec_t        vec [8];
    logic [63:0] mem [logic [63:0]];
    logic [63:0] model_valm;

    mem_request_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .icode     (icode),
        .valA      (valA),
        .valE      (valE),
        .valP      (valP),
        .busy      (busy),
        .done      (done),
        .valM      (valM),
        .mem_err   (mem_err),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] junk();
        return {32'hDEAD_BEEF, 32'($urandom())};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one operation as stage + memory, then checks what was observed.
    task automatic run_op(input vec_t v);
        int          nreq;
        int          nwait;
        int          lat;
        bit          in_wait;
        bit          seen;
        bit          unstable;
        bit          busy_low;
        bit          post_bad;
        logic        w;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] vm;
        logic        err;
        nreq = 0; nwait = 0; lat = -1; in_wait = 0; seen = 0;
        unstable = 0; busy_low = 0; w = 0; addr = '0; wdata = '0;
        vm = '0; err = 0;
        start = 1'b1; icode = v.icode;
        valA = v.a; valE = v.e; valP = v.p;
        req_ready = v.junk; rsp_valid = v.junk; rsp_rdata = junk();
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            start = (k == 1) && v.poke;
            if (k == 1 && v.poke) begin
                icode = 4'h4;
                valA = junk(); valE = junk(); valP = junk();
            end
            if (done) begin
                lat = k; vm = valM; err = mem_err;
                break;
            end
            if (!busy) busy_low = 1;
            if (req_valid) begin
                if (!seen) begin
                    seen = 1; w = req_write; addr = req_addr; wdata = req_wdata;
                end else if (req_write !== w || req_addr !== addr || req_wdata !== wdata) begin
                    unstable = 1;
                end
                req_ready = (nreq >= v.rdly);
                nreq++;
                rsp_valid = v.junk; rsp_rdata = junk();
            end else if (in_wait) begin
                rsp_valid = (nwait >= v.sdly);
                rsp_rdata = rsp_valid ? v.rdata : junk();
                nwait++;
                req_ready = v.junk;
            end else begin
                req_ready = v.junk; rsp_valid = v.junk; rsp_rdata = junk();
            end
            if (req_valid && req_ready && !req_write) in_wait = 1;
        end
        @(posedge clk); #1;
        post_bad = done | busy | req_valid;
        start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("req_issued", 64'(seen), 64'(v.exp_req));
        if (v.exp_req) begin
            check("req_write", 64'(w), 64'(v.exp_w));
            check("req_addr", addr, v.exp_addr);
            if (v.exp_w) check("req_wdata", wdata, v.exp_wdata);
        end
        check("valM", vm, v.exp_valm);
        check("mem_err", 64'(err), 64'(v.exp_err));
        check("req_stable", 64'(unstable), 64'd0);
        check("busy_during_op", 64'(busy_low), 64'd0);
        check("done_one_cycle", 64'(post_bad), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        bit   saw;
        bit   is_w;
        bit   is_r;
        logic [63:0] ad;
        logic [63:0] wd;

        //       icode  a        e         p         rd sd rdata      pk jk  req w addr      wdata     valm       lat err
        vec[0] = '{4'h4, 64'h55, 64'h10,  64'h0,    0, 0, 64'h0,     0, 0,  1, 1, 64'h10,  64'h55,   64'h0,     2, 0};
        vec[1] = '{4'h5, 64'h0,  64'h20,  64'h0,    3, 2, 64'hABCD,  0, 1,  1, 0, 64'h20,  64'h0,    64'hABCD,  8, 0};
        vec[2] = '{4'h8, 64'h0,  64'h3F8, 64'h1234, 0, 0, 64'h0,     0, 0,  1, 1, 64'h3F8, 64'h1234, 64'hABCD,  2, 0};
        vec[3] = '{4'h9, 64'h3F8,64'h0,   64'h0,    0, 0, 64'h1234,  0, 0,  1, 0, 64'h3F8, 64'h0,    64'h1234,  3, 0};
        vec[4] = '{4'h1, 64'h0,  64'h0,   64'h0,    0, 0, 64'h0,     1, 0,  0, 0, 64'h0,   64'h0,    64'h1234,  1, 0};
        vec[5] = '{4'hA, 64'h99, 64'h3F0, 64'h7,    1, 0, 64'h0,     1, 1,  1, 1, 64'h3F0, 64'h99,   64'h1234,  3, 0};
`ifdef MEM_BOUNDS_CHECK_EN
        vec[6] = '{4'hB, 64'h0,  64'd1024,64'h0,    0, 0, 64'h77,    0, 0,  0, 0, 64'h0,   64'h0,    64'h1234,  1, 1};
        vec[7] = '{4'h5, 64'h0,  64'd1023,64'h0,    0, 0, 64'h5A5A,  0, 0,  1, 0, 64'd1023,64'h0,    64'h5A5A,  3, 0};
`else
        vec[6] = '{4'hB, 64'h0,  64'd1024,64'h0,    0, 0, 64'h77,    0, 0,  1, 0, 64'd1024,64'h0,    64'h77,    3, 0};
        vec[7] = '{4'h5, 64'h0,  64'd1023,64'h0,    0, 0, 64'h5A5A,  0, 0,  1, 0, 64'd1023,64'h0,    64'h5A5A,  3, 0};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_req_write", 64'(req_write), 64'd0);
        check("rst_mem_err", 64'(mem_err), 64'd0);
        check("rst_valM", valM, 64'd0);
        check("rst_req_addr", req_addr, 64'd0);
        check("rst_req_wdata", req_wdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_op(vec[i]);

        // Reset while the read waits for its response.
        start = 1'b1; icode = 4'h5; valE = 64'h40; req_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rwait_req_valid", 64'(req_valid), 64'd1);
        @(posedge clk); #1;
        check("rwait_in_wait", 64'({busy, req_valid}), 64'b10);
        rst_n = 1'b0; rsp_valid = 1'b1; rsp_rdata = 64'hFEED;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rwait_busy", 64'(busy), 64'd0);
        check("rwait_req_valid_drop", 64'(req_valid), 64'd0);
        check("rwait_valM", valM, 64'd0);
        check("rwait_req_addr", req_addr, 64'd0);
        saw = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw = 1;
            @(posedge clk); #1;
        end
        check("rwait_no_done", 64'(saw), 64'd0);
        check("rwait_valM_kept", valM, 64'd0);
        rsp_valid = 1'b0; req_ready = 1'b0;
        model_valm = '0;

        for (int n = 0; n < 60; n++) begin
            v.icode = 4'($urandom_range(0, 15));
            v.a = ($urandom_range(0, 3) == 0) ? {32'($urandom()), 32'($urandom())}
                                              : 64'($urandom_range(0, 1100));
            v.e = ($urandom_range(0, 3) == 0) ? {32'($urandom()), 32'($urandom())}
                                              : 64'($urandom_range(0, 1100));
            v.p = {32'($urandom()), 32'($urandom())};
            v.rdly = $urandom_range(0, 3);
            v.sdly = $urandom_range(0, 3);
            v.poke = 1'($urandom_range(0, 1));
            v.junk = 1'($urandom_range(0, 1));
            is_w = v.icode inside {4'h4, 4'h8, 4'hA};
            is_r = v.icode inside {4'h5, 4'h9, 4'hB};
            ad = (v.icode == 4'h9) ? v.a : v.e;
            wd = (v.icode == 4'h8) ? v.p : v.a;
            v.exp_err = BOUNDS && (is_w || is_r) && (ad >= 64'd1024);
            v.exp_req = (is_w || is_r) && !v.exp_err;
            v.exp_w = is_w;
            v.exp_addr = ad;
            v.exp_wdata = wd;
            v.rdata = junk();
            if (is_r && v.exp_req) begin
                if (mem.exists(ad)) v.rdata = mem[ad];
                model_valm = v.rdata;
            end
            if (is_w && v.exp_req) mem[ad] = wd;
            v.exp_valm = model_valm;
            v.exp_lat = !v.exp_req ? 1 : (is_w ? 2 + v.rdly : 3 + v.rdly + v.sdly);
            run_op(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
